// File: rtl/accum_sched.sv
// accum_sched: two-requester round-robin scheduler running a triangular accumulator job.
// Define ACCUM_SCHED_ASSERT_EN to compile in the concurrent assertion checks.
module accum_sched #(
   parameter int WIDTH = 15,
   parameter int LIMIT = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [7:0]       n0,
   input  logic [7:0]       n1,
   input  logic             step_en,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [1:0]       state_dbg
);

   // Handshake: reqN is a level held until gntN pulses for one cycle; grants are
   // issued only from IDLE, and nN is captured on the same edge that raises gntN.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] nlat_q, nlat_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             done_id_q, done_id_d;

   logic             win;
   logic [7:0]       n_sel;
   logic [31:0]      n_sel32;
   logic [WIDTH-1:0] n_cap;

   // On a tie the requester that was not served last wins.
   always_comb begin
      win     = (req0 && req1) ? ~last_q : req1;
      n_sel   = win ? n1 : n0;
      n_sel32 = {24'd0, n_sel};
      if (n_sel32 > 32'(LIMIT)) begin
         n_cap = LIMIT_W;
      end else begin
         n_cap = WIDTH'(n_sel32);
      end
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      nlat_d    = nlat_q;
      owner_d   = owner_q;
      last_d    = last_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      done_id_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d = S_RUN;
               owner_d = win;
               last_d  = win;
               nlat_d  = n_cap;
               x_d     = WIDTH'(1);
               y_d     = '0;
               gnt0_d  = ~win;
               gnt1_d  = win;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            // Completion takes priority over stepping, so step_en is a don't-care here.
            if (y_q == nlat_q) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               done_id_d = owner_q;
            end else if (step_en) begin
               x_d = x_q + y_q;
               y_d = y_q + WIDTH'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         x_q       <= WIDTH'(1);
         y_q       <= '0;
         nlat_q    <= '0;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         nlat_q    <= nlat_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign state_dbg = state_q;

`ifdef ACCUM_SCHED_ASSERT_EN
   a_x_ge_y: assert property (@(posedge clk) disable iff (rst)
      busy_q |-> (x_q >= y_q));
   a_y_le_n: assert property (@(posedge clk) disable iff (rst)
      (y_q <= nlat_q) && (nlat_q <= LIMIT_W));
   a_gnt_1h: assert property (@(posedge clk) disable iff (rst)
      !(gnt0_q && gnt1_q));
   a_done_st: assert property (@(posedge clk) disable iff (rst)
      done_q |-> (state_q == S_DONE));
`endif

endmodule

// File: tb/tb_accum_sched.sv
// Randomized self-checking bench for accum_sched against a closed-form job/arbiter model.
module tb_accum_sched;
  localparam int WIDTH = 15;
  localparam int LIMIT = 200;
  localparam int W     = 1 + 2 * WIDTH;

  logic             clk;
  logic             rst;
  logic             req0, req1;
  logic [7:0]       n0, n1;
  logic             step_en;
  logic             gnt0, gnt1, busy, done, done_id;
  logic [WIDTH-1:0] x_out, y_out;
  logic [1:0]       state_dbg;

  accum_sched #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .n0(n0), .n1(n1),
    .step_en(step_en), .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .x_out(x_out), .y_out(y_out), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic last_m;
  int pat[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cap_n(input int n);
    return (n > LIMIT) ? LIMIT : n;
  endfunction

  function automatic int tri_x(input int m);
    return (1 + (m * (m - 1)) / 2) & ((1 << WIDTH) - 1);
  endfunction

  task automatic do_reset();
    rst = 1'b1; req0 = 0; req1 = 0; n0 = 0; n1 = 0; step_en = 0;
    last_m = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_x", x_out, 1);
    check("rst_y", y_out, 0);
    check("rst_ctl", {gnt0, gnt1, busy, done, done_id}, 0);
    rst = 1'b0;
  endtask

  task automatic request(input int id, input int n);
    if (id == 0) begin req0 = 1'b1; n0 = 8'(n); end
    else begin req1 = 1'b1; n1 = 8'(n); end
  endtask

  // mode 0: step_en always 1, mode 1: random, mode 2: pat[] then 1
  task automatic serve(input int mode);
    logic win;
    int m, k, w, cyc, idx;
    logic got, fin, exp_done, en;
    logic [WIDTH-1:0] xw, yw, x_hold, y_hold;
    logic [W-1:0] e;
    if (!req0) n0 = 8'($urandom_range(0, 255));
    if (!req1) n1 = 8'($urandom_range(0, 255));
    win = (req0 && req1) ? ~last_m : req1;
    m = cap_n(win ? int'(n1) : int'(n0));
    xw = WIDTH'(tri_x(m));
    yw = WIDTH'(m);
    exp_q.push_back({win, xw, yw});
    w = 0; got = 0;
    while (!got && w < 8) begin
      step_en = 1'($urandom_range(0, 1));
      @(negedge clk);
      w++;
      if (gnt0 || gnt1) got = 1;
    end
    check("gnt_lat", w, 1);
    check("gnt_who", {gnt1, gnt0}, win ? 2 : 1);
    last_m = win;
    if (win) req1 = 1'b0; else req0 = 1'b0;
    k = 0; cyc = 0; fin = 0; idx = 0;
    while (!fin && cyc < 2000) begin
      if (mode == 0) en = 1'b1;
      else if (mode == 1) en = 1'($urandom_range(0, 1));
      else begin
        en = (idx < pat.size()) ? 1'(pat[idx]) : 1'b1;
        idx++;
      end
      step_en = en;
      exp_done = (k == m);
      if (!exp_done && en) k++;
      @(negedge clk);
      cyc++;
      check("done", done, exp_done);
      check("gnt_busy", {gnt1, gnt0}, 0);
      check("busy", busy, 1);
      if (exp_done) begin
        fin = 1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("done_id", done_id, e[W-1]);
          check("x_res", x_out, e[2*WIDTH-1:WIDTH]);
          check("y_res", y_out, e[WIDTH-1:0]);
        end else begin
          check("sb_underflow", 1, 0);
        end
      end else begin
        check("y_step", y_out, k);
      end
    end
    if (!fin) check("job_timeout", cyc, 0);
    x_hold = x_out; y_hold = y_out;
    @(negedge clk);
    check("idle_ctl", {gnt0, gnt1, busy, done}, 0);
    check("hold_x", x_out, x_hold);
    check("hold_y", y_out, y_hold);
  endtask

  initial begin
    int r;
    logic got;
    do_reset();

    // tie after reset: requester 0 first, then 1
    request(0, 3); request(1, 3);
    serve(0);
    serve(0);

    // single job, capped job, stalled job, zero job
    request(0, 5);   serve(0);
    request(1, 255); serve(0);
    pat = '{1, 0, 0, 1, 1, 1};
    request(0, 4);   serve(2);
    request(0, 0);   serve(0);

    // reset in the middle of a job
    request(0, 10);
    step_en = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (gnt0) got = 1;
    end
    check("mr_gnt", got, 1);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    check("mr_y2", y_out, 2);
    rst = 1'b1;
    #1;
    check("mr_x", x_out, 1);
    check("mr_y", y_out, 0);
    check("mr_ctl", {gnt0, gnt1, busy, done, done_id}, 0);
    @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mr_nodone", {busy, done}, 0);
    end

    // randomized traffic
    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(1, 3);
      if (r[0]) request(0, ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 40));
      if (r[1]) request(1, ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 40));
      while (req0 || req1) serve(1);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    rst = 1'b1;
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/accum_sched.md
ACCUM_SCHED -- requirements
Module: accum_sched

Interface
REQ-001 Parameter WIDTH, default 15, accumulator and counter width.
REQ-002 Parameter LIMIT, default 200, hard cap on steps per job.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  job request from requester 0 / 1; level, held until the matching gnt.
REQ-006 n0, n1  input  8 each  requested step count for requester 0 / 1; sampled at grant.
REQ-007 step_en  input  1  step enable; while low, RUN state holds the accumulator.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse to requester 0 / 1.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 done_id  output  1  requester index of the completed job; valid with done.
REQ-012 x_out, y_out  output  WIDTH each  accumulator value x and step counter y; x_out and y_out hold the last job's result while IDLE.

Function
REQ-013 FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE with any req high: the next edge enters RUN, pulses the winner's gnt, latches owner, latches n_lat = min(n_sel, LIMIT), and loads x=1, y=0.
REQ-015 Arbitration: round-robin with a 1-bit last-served pointer; on a tie the requester not last served wins; the pointer resets to favour requester 0.
REQ-016 Grant latency: a req seen in IDLE at edge E gives gnt high in the cycle after E, which is also the first RUN cycle.
REQ-017 RUN: each edge with step_en=1 and y<n_lat performs x<=x+y and y<=y+1 simultaneously, using pre-edge values.
REQ-018 RUN: an edge with y==n_lat moves to DONE; step_en is ignored at that point.
REQ-019 DONE lasts exactly one cycle with done=1 and done_id=owner, then returns to IDLE; new requests are sampled only in IDLE.
REQ-020 With step_en held high, a job of n steps (after capping) has done high exactly n+1 cycles after its gnt cycle; n=0 gives done in the cycle after gnt.
REQ-021 Arithmetic is unsigned, modulo 2^WIDTH; with the defaults no wrap can occur, since the maximum x is 19901.
REQ-022 Invariant: while busy, x = 1 + y(y-1)/2, hence x >= y.
REQ-023 gnt0 and gnt1 are never high together; neither pulses while busy.
REQ-024 An unrequested requester's n input is ignored.

Reset
REQ-025 rst high asynchronously forces: IDLE, x=1, y=0, n_lat=0, owner=0, pointer to favour requester 0, and gnt0, gnt1, busy, done, done_id all 0.
REQ-026 Reset mid-RUN abandons the job with no done pulse; the requester must re-request.
REQ-027 After rst deasserts, the first edge may grant.

Configuration
REQ-028 Macro ACCUM_SCHED_ASSERT_EN: when defined, concurrent assertions are compiled in, checking:
  - REQ-022 (x >= y while busy);
  - y <= n_lat <= LIMIT;
  - gnt one-hot-or-zero;
  - done only in DONE.
REQ-029 When ACCUM_SCHED_ASSERT_EN is undefined, no assertion code is present, and ports and behaviour are identical.

Verification
REQ-030 Single job: req0=1, n0=5, step_en=1 -> gnt0 pulse; done 6 cycles later with done_id=0, x_out=11, y_out=5.
REQ-031 Cap: req1=1, n1=255 -> y stops at 200; done with x_out=19901, y_out=200, done_id=1.
REQ-032 Tie after reset: req0=req1=1, n0=n1=3 -> gnt0 first, with done x=4, y=3; then gnt1 with the same result; gnt0 and gnt1 never overlap.
REQ-033 Stall: n0=4, step_en toggled 1,0,0,1,1,1 -> y advances only on enabled edges; done after 4 enabled steps with x=7, y=4.
REQ-034 Zero job: n0=0 -> done the cycle after gnt with x_out=1, y_out=0.
REQ-035 Reset mid-RUN: rst pulsed at y=2 -> immediate IDLE, x=1, y=0, busy=0, no done pulse; with ACCUM_SCHED_ASSERT_EN defined, no assertion fires in any scenario.
